// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: short-width aliases, the
// arbiter state encoding and the starvation counter width.
package mem_port_arbiter_pkg;

    typedef logic        u1;
    typedef logic [1:0]  u2;
    typedef logic [2:0]  u3;
    typedef logic [31:0] u32;

    localparam int ARB_WAIT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU,
        ARB_DBG
    } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the debug requester has waited,
// with a flag once that count reaches the threshold where debug outranks the CPU.
module arb_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    output logic at_thresh
);

    localparam logic [ARB_WAIT_W-1:0] CNT_SAT = '1;
    localparam logic [ARB_WAIT_W-1:0] THRESH  = ARB_WAIT_W'(MAX_WAIT);

    logic [ARB_WAIT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!waiting) begin
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_thresh = (cnt >= THRESH);

endmodule

// File: rtl/mem_port_arbiter.sv
// Owns the unified memory port: fixed CPU priority with a starvation escape
// for the debug/DMA requester, and a stall back to the multicycle core.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam u3 LAT_LAST = u3'(MEM_LAT);

    arb_state_t state, state_nxt;
    u3          lat_cnt, lat_nxt;
    u32         cpu_rdata_q, dbg_rdata_q;
    u1          starve, dbg_waiting, dbg_win;
    u1          cpu_rd_cycle, dbg_rd_cycle, cpu_done;

    assign dbg_waiting = dbg_req && !dbg_gnt;

    arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .waiting   (dbg_waiting),
        .at_thresh (starve)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        lat_nxt      = lat_cnt;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dbg_gnt      = 1'b0;
        dbg_win      = 1'b0;
        cpu_rd_cycle = 1'b0;
        dbg_rd_cycle = 1'b0;
        cpu_done     = 1'b0;

        if (!reset) begin
            unique case (state)
                ARB_IDLE: begin
                    dbg_win = dbg_req && (starve || !cpu_req);
                    if (dbg_win) begin
                        mem_en    = 1'b1;
                        mem_we    = dbg_we;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_wdata;
                        dbg_gnt   = 1'b1;
                        if (!dbg_we) begin
                            state_nxt = ARB_DBG;
                            lat_nxt   = 3'd1;
                        end
                    end else if (cpu_req) begin
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        cpu_done  = cpu_we;
                        if (!cpu_we) begin
                            state_nxt = ARB_CPU;
                            lat_nxt   = 3'd1;
                        end
                    end
                end
                ARB_CPU, ARB_DBG: begin
                    // Data arrives MEM_LAT cycles after issue; the port frees up after that cycle.
                    if (lat_cnt == LAT_LAST) begin
                        cpu_rd_cycle = (state == ARB_CPU);
                        dbg_rd_cycle = (state == ARB_DBG);
                        cpu_done     = (state == ARB_CPU);
                        state_nxt    = ARB_IDLE;
                        lat_nxt      = '0;
                    end else begin
                        lat_nxt = lat_cnt + 3'd1;
                    end
                end
                default: begin
                    state_nxt = ARB_IDLE;
                    lat_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ARB_IDLE;
            lat_cnt     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            if (cpu_rd_cycle) cpu_rdata_q <= mem_rdata;
            if (dbg_rd_cycle) dbg_rdata_q <= mem_rdata;
        end
    end

    assign cpu_stall  = cpu_req && !reset && !cpu_done;
    assign cpu_rdata  = cpu_rd_cycle ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rd_cycle ? mem_rdata : dbg_rdata_q;
    assign dbg_rvalid = dbg_rd_cycle;

endmodule
